// File: rtl/game_state_frame_tx.sv
// Snapshots the local game state on `start` and streams it as a fixed 10-byte
// frame (sync, 6 position bytes, scores, flags, XOR checksum) over valid/ready.
module game_state_frame_tx #(
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    parameter int         FRAME_LEN = 10
) (
    input  logic        clk65MHz,
    input  logic        rst,
    input  logic        start,
    input  logic [11:0] pl1_posx,
    input  logic [11:0] pl1_posy,
    input  logic [11:0] ball_xpos,
    input  logic [11:0] ball_ypos,
    input  logic [3:0]  score_pl1,
    input  logic [3:0]  score_pl2,
    input  logic        endgame,
    input  logic        whistle_play,
    input  logic        last_touch,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic        frame_done
);

    localparam logic [3:0] LAST_IDX = 4'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_DONE
    } state_t;

    state_t      state;
    logic [3:0]  idx;
    logic        pending;
    logic [63:0] snap;
    logic [7:0]  csum;
    logic [63:0] live_word;

    // Payload bytes 1..8 packed MSB-first so byte k sits at bits [71-8k -: 8].
    assign live_word = {pl1_posx, pl1_posy, ball_xpos, ball_ypos,
                        score_pl1, score_pl2,
                        5'b0, endgame, whistle_play, last_touch};

    function automatic logic [7:0] xor_bytes(input logic [63:0] w);
        logic [7:0] acc;
        acc = 8'h00;
        for (int i = 0; i < 8; i++) begin
            acc = acc ^ w[8*i +: 8];
        end
        return acc;
    endfunction

    function automatic logic [7:0] frame_byte(input logic [3:0]  i,
                                              input logic [63:0] w,
                                              input logic [7:0]  c);
        logic [7:0] b;
        case (i)
            4'd0:    b = SYNC_BYTE;
            4'd1:    b = w[63:56];
            4'd2:    b = w[55:48];
            4'd3:    b = w[47:40];
            4'd4:    b = w[39:32];
            4'd5:    b = w[31:24];
            4'd6:    b = w[23:16];
            4'd7:    b = w[15:8];
            4'd8:    b = w[7:0];
            default: b = c;
        endcase
        return b;
    endfunction

    always_ff @(posedge clk65MHz or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            idx        <= 4'd0;
            pending    <= 1'b0;
            snap       <= 64'd0;
            csum       <= 8'd0;
            tx_data    <= 8'd0;
            tx_valid   <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    tx_valid <= 1'b0;
                    busy     <= start;
                    if (start) begin
                        snap     <= live_word;
                        csum     <= xor_bytes(live_word);
                        idx      <= 4'd0;
                        tx_data  <= SYNC_BYTE;
                        tx_valid <= 1'b1;
                        state    <= S_SEND;
                    end
                end

                S_SEND: begin
                    busy <= 1'b1;
                    // Only one request is remembered; extra starts are dropped.
                    if (start) begin
                        pending <= 1'b1;
                    end
                    if (tx_ready) begin
                        if (idx == LAST_IDX) begin
                            frame_done <= 1'b1;
                            tx_valid   <= 1'b0;
                            state      <= S_DONE;
                        end else begin
                            idx     <= idx + 4'd1;
                            tx_data <= frame_byte(idx + 4'd1, snap, csum);
                        end
                    end
                end

                S_DONE: begin
                    tx_valid <= 1'b0;
                    // A queued request is served with inputs as they are now.
                    if (pending || start) begin
                        pending  <= 1'b0;
                        snap     <= live_word;
                        csum     <= xor_bytes(live_word);
                        idx      <= 4'd0;
                        tx_data  <= SYNC_BYTE;
                        tx_valid <= 1'b1;
                        busy     <= 1'b1;
                        state    <= S_SEND;
                    end else begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                end

                default: begin
                    tx_valid <= 1'b0;
                    busy     <= 1'b0;
                    pending  <= 1'b0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/game_state_frame_tx.md
Name: game_state_frame_tx

Overview:
- Serialises one snapshot of the local game state into a fixed 10-byte frame and streams it byte-by-byte to the UART transmitter over a valid/ready handshake.
- Sits inside uart_top, directly upstream of the byte-level UART TX.
- The game logic pulses `start` once per video frame; this block sends positions, scores and event flags to the remote board.

Parameters:
- SYNC_BYTE, 8'hA5, first byte of every frame.
- FRAME_LEN, 10, bytes per frame. Fixed; other values are unsupported.

Ports:
- clk65MHz  input  1  system clock; all logic on its rising edge
- rst  input  1  reset, asynchronous, active-high
- start  input  1  one-cycle request to snapshot inputs and send a frame
- pl1_posx  input  12  player 1 x position
- pl1_posy  input  12  player 1 y position
- ball_xpos  input  12  ball x position
- ball_ypos  input  12  ball y position
- score_pl1  input  4  player 1 score
- score_pl2  input  4  player 2 score
- endgame  input  1  game-over flag
- whistle_play  input  1  whistle event flag
- last_touch  input  1  last player to touch the ball
- tx_data  output  8  byte offered to the UART TX
- tx_valid  output  1  tx_data is valid
- tx_ready  input  1  UART TX accepts the byte this cycle (transfer = tx_valid & tx_ready)
- busy  output  1  frame in progress or pending
- frame_done  output  1  one-cycle pulse after the last byte transfers

Behaviour:
- Reset (async, rst=1) drives outputs: tx_data=0, tx_valid=0, busy=0, frame_done=0.
- Reset also clears internals: state=IDLE, byte index=0, pending=0, snapshot=0, checksum=0.
- Reset mid-frame aborts the frame immediately; no partial continuation after release.
- Frame layout, bytes 0..9:
  - Byte 0: SYNC_BYTE.
  - Bytes 1..6: big-endian split of the 48-bit word {pl1_posx, pl1_posy, ball_xpos, ball_ypos}.
  - Byte 7: {score_pl1, score_pl2}.
  - Byte 8: {5'b0, endgame, whistle_play, last_touch}.
  - Byte 9: XOR of bytes 1..8.
- Snapshot: all inputs and the checksum are registered on the cycle `start` is accepted. Input changes afterwards do not affect the frame in flight.
- FSM states:
  - IDLE: tx_valid=0. If start=1, capture the snapshot, set index=0, go to SEND. busy rises the cycle after start.
  - SEND: tx_valid=1 and tx_data=byte[index], both registered.
    - On transfer with index<9: index increments. The next byte is presented the following cycle with tx_valid held high (back-to-back allowed).
    - On transfer with index=9: frame_done pulses for 1 cycle, then go to DONE.
    - With tx_ready=0: tx_valid and tx_data hold stable, with no limit on the stall length.
  - DONE: one cycle, tx_valid=0. If pending=1, clear it, capture a fresh snapshot and go to SEND; otherwise go to IDLE.
- Latency: start at cycle N gives tx_valid=1 with SYNC_BYTE at cycle N+1. With tx_ready held at 1, the last byte transfers at N+10.
- start while busy: sets pending (1-deep). Further starts while pending=1 are dropped. The pending snapshot is taken at DONE, not at the time of the request.
- start in the same cycle as the final transfer is treated as pending.
- busy=1 in SEND and DONE, or whenever pending=1.
- tx_valid never deasserts while in SEND without a transfer.

Test Plan:
- Basic frame: pl1_posx=12'h123, pl1_posy=12'h456, ball_xpos=12'h789, ball_ypos=12'hABC, scores 3/5, endgame=0, whistle_play=1, last_touch=1, tx_ready=1, pulse start.
  - Bytes A5 12 34 56 78 9A BC 35 03 18 on consecutive cycles.
  - frame_done pulses once; busy falls afterwards.
- Backpressure: same inputs, tx_ready toggles 1-cycle-on / 3-cycles-off.
  - Same 10 bytes, each held stable while tx_ready=0; no duplicates or skips.
- Snapshot isolation: change ball_xpos to 12'hFFF at byte 2.
  - Bytes 3..4 still 56 78; checksum still 18.
- Pending: pulse start at byte 4, then twice more.
  - Exactly two frames sent.
  - The second frame carries the input values present at its DONE cycle.
  - One idle (tx_valid=0) cycle between the frames.
- Reset mid-frame: assert rst asynchronously at byte 6.
  - tx_valid=0 and busy=0 immediately.
  - After release, the next start emits a full frame beginning with A5.
- Idle: no start for 1000 cycles.
  - tx_valid=0 and busy=0 throughout.
